// File: rtl/simon_pkg.sv
// Shared types and helpers for the memory-tile game round sequencer:
// FSM state encoding, difficulty levels and key/length decoding.
package simon_pkg;

    localparam int unsigned MAX_LEN = 9;

    typedef logic [1:0] tile_t;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        GEN           = 4'd1,
        SHOW_ON       = 4'd2,
        SHOW_HOLD     = 4'd3,
        SHOW_OFF      = 4'd4,
        SHOW_GAP      = 4'd5,
        INPUT_WAIT    = 4'd6,
        INPUT_RELEASE = 4'd7,
        WIN           = 4'd8,
        LOSE          = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        LEVEL_EASY     = 2'd0,
        LEVEL_NORMAL   = 2'd1,
        LEVEL_HARD     = 2'd2,
        LEVEL_HARD_ALT = 2'd3
    } level_t;

    function automatic logic [3:0] level_len(input logic [1:0] lvl);
        case (lvl)
            LEVEL_EASY:   return 4'd3;
            LEVEL_NORMAL: return 4'd6;
            default:      return 4'd9;
        endcase
    endfunction

    // Index of the single asserted bit; callers guarantee a one-hot input.
    function automatic tile_t key_index(input logic [3:0] pressed);
        case (pressed)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/simon_round_sequencer_if.sv
// Sequence-storage and tile-draw signals of the round sequencer.
// master = sequencer side, slave = storage/datapath side.
interface simon_round_sequencer_if;
    import simon_pkg::*;

    logic       seq_gen;
    logic [3:0] seq_addr;
    tile_t      seq_tile;
    logic       draw_req;
    tile_t      draw_tile;
    logic       draw_flash;
    logic       draw_done;

    modport master (
        output seq_gen, seq_addr, draw_req, draw_tile, draw_flash,
        input  seq_tile, draw_done
    );

    modport slave (
        input  seq_gen, seq_addr, draw_req, draw_tile, draw_flash,
        output seq_tile, draw_done
    );

endinterface

// File: rtl/simon_round_sequencer_cycle_timer.sv
// Loadable down-counter shared by the flash-hold, gap and input-timeout phases.
// expired is high while the count sits at zero.
module cycle_timer #(
    parameter int unsigned TIMER_W = 25
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/simon_round_sequencer.sv
// Game controller: replays the stored tile sequence, then checks player presses.
// Optional build macro INPUT_TIMEOUT_EN adds a no-press timeout in INPUT_WAIT.
module simon_round_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned FLASH_CYCLES   = 25000000,
    parameter int unsigned GAP_CYCLES     = 12500000,
    parameter int unsigned TIMER_W        = 25,
    parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [1:0]              level,
    input  logic [3:0]              player_key,
    output logic [3:0]              round,
    output logic                    busy,
    output logic                    win,
    output logic                    lose,
    simon_round_sequencer_if.master bus
);

    localparam int unsigned TIMER_MAX = (32'd1 << TIMER_W) - 32'd1;
    // Timer counts down to zero inclusive, so loading N-1 gives exactly N cycles.
    localparam logic [TIMER_W-1:0] FLASH_LOAD = TIMER_W'(FLASH_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    if (FLASH_CYCLES < 1 || FLASH_CYCLES - 1 > TIMER_MAX ||
        GAP_CYCLES < 1 || GAP_CYCLES - 1 > TIMER_MAX || TIMEOUT_CYCLES < 1) begin : g_bad_timing
        $error("simon_round_sequencer: cycle counts must be >= 1 and fit in TIMER_W");
    end

`ifdef INPUT_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
    if (TIMEOUT_CYCLES - 1 > TIMER_MAX) begin : g_bad_timeout
        $error("simon_round_sequencer: TIMEOUT_CYCLES does not fit in TIMER_W");
    end
`endif

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         round_q, round_d;
    logic [3:0]         target_len_q, target_len_d;
    logic               seq_gen_q, seq_gen_d;
    logic               draw_req_q, draw_req_d;
    tile_t              draw_tile_q, draw_tile_d;
    logic               draw_flash_q, draw_flash_d;
    logic [3:0]         key_meta_q, key_meta_d;
    logic [3:0]         key_sync_q, key_sync_d;
    logic               armed_q, armed_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expired;
    logic               key_press;
    logic               all_released;

    cycle_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // A press needs all keys released on the previous cycle and exactly one low now.
    assign all_released = (key_sync_q == 4'hF);
    assign key_press    = armed_q && $onehot(~key_sync_q);

    // NOTE: every _d gets a default first so no path through the block infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        round_d      = round_q;
        target_len_d = target_len_q;
        seq_gen_d    = 1'b0;
        draw_req_d   = draw_req_q;
        draw_tile_d  = draw_tile_q;
        draw_flash_d = draw_flash_q;
        key_meta_d   = player_key;
        key_sync_d   = key_meta_q;
        armed_d      = all_released;
        timer_load   = 1'b0;
        timer_val    = '0;

        if (start) begin
            state_d      = GEN;
            seq_gen_d    = 1'b1;
            round_d      = 4'd1;
            idx_d        = 4'd0;
            target_len_d = level_len(level);
            draw_req_d   = 1'b0;
        end else begin
            case (state_q)
                GEN: begin
                    idx_d   = 4'd0;
                    state_d = SHOW_ON;
                end
                SHOW_ON: begin
                    if (!draw_req_q) begin
                        draw_req_d   = 1'b1;
                        draw_tile_d  = bus.seq_tile;
                        draw_flash_d = 1'b1;
                    end else if (bus.draw_done) begin
                        draw_req_d = 1'b0;
                        timer_load = 1'b1;
                        timer_val  = FLASH_LOAD;
                        state_d    = SHOW_HOLD;
                    end
                end
                SHOW_HOLD: begin
                    if (timer_expired) state_d = SHOW_OFF;
                end
                SHOW_OFF: begin
                    if (!draw_req_q) begin
                        draw_req_d   = 1'b1;
                        draw_flash_d = 1'b0;
                    end else if (bus.draw_done) begin
                        draw_req_d = 1'b0;
                        timer_load = 1'b1;
                        timer_val  = GAP_LOAD;
                        state_d    = SHOW_GAP;
                    end
                end
                SHOW_GAP: begin
                    if (timer_expired) begin
                        if (idx_q + 4'd1 < round_q) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = SHOW_ON;
                        end else begin
                            idx_d   = 4'd0;
                            state_d = INPUT_WAIT;
`ifdef INPUT_TIMEOUT_EN
                            timer_load = 1'b1;
                            timer_val  = TIMEOUT_LOAD;
`endif
                        end
                    end
                end
                INPUT_WAIT: begin
                    if (key_press) begin
                        state_d = (key_index(~key_sync_q) == bus.seq_tile) ? INPUT_RELEASE : LOSE;
                    end
`ifdef INPUT_TIMEOUT_EN
                    else if (timer_expired) begin
                        state_d = LOSE;
                    end
`endif
                end
                INPUT_RELEASE: begin
                    if (all_released) begin
                        if (idx_q + 4'd1 < round_q) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = INPUT_WAIT;
`ifdef INPUT_TIMEOUT_EN
                            timer_load = 1'b1;
                            timer_val  = TIMEOUT_LOAD;
`endif
                        end else if (round_q == target_len_q) begin
                            state_d = WIN;
                        end else begin
                            round_d = (round_q == 4'(MAX_LEN)) ? round_q : round_q + 4'd1;
                            idx_d   = 4'd0;
                            state_d = SHOW_ON;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            round_q      <= 4'd0;
            target_len_q <= 4'd0;
            seq_gen_q    <= 1'b0;
            draw_req_q   <= 1'b0;
            draw_tile_q  <= 2'd0;
            draw_flash_q <= 1'b0;
            key_meta_q   <= 4'hF;
            key_sync_q   <= 4'hF;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            round_q      <= round_d;
            target_len_q <= target_len_d;
            seq_gen_q    <= seq_gen_d;
            draw_req_q   <= draw_req_d;
            draw_tile_q  <= draw_tile_d;
            draw_flash_q <= draw_flash_d;
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
            armed_q      <= armed_d;
        end
    end

    assign bus.seq_gen    = seq_gen_q;
    assign bus.seq_addr   = idx_q;
    assign bus.draw_req   = draw_req_q;
    assign bus.draw_tile  = draw_tile_q;
    assign bus.draw_flash = draw_flash_q;

    assign round = round_q;
    assign busy  = !(state_q inside {IDLE, WIN, LOSE});
    assign win   = (state_q == WIN);
    assign lose  = (state_q == LOSE);

endmodule
